// File: rtl/conv_result_packer.sv
// Sink for the 3x3 convolution result stream: drops border results, requantizes
// the rest to bytes, packs four per word and queues them on a valid/ready port.
module conv_result_packer #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  shift_amt,
  input  logic        relu_en,
  input  logic        in_valid,
  input  logic [31:0] in_pixel,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        overflow,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [4:0]         shift_q;
  logic               relu_q;
  logic               in_done;
  logic               sample, qualify, at_last_px;
  logic signed [31:0] shifted;
  logic [7:0]         q_byte;
  logic               rq_valid, rq_last;
  logic [7:0]         rq_byte;
  logic [31:0]        pack_data, push_word;
  logic [1:0]         lane;
  logic               push_req, push_ok, pop, fifo_empty;
  logic [32:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [PW:0]        count;
  logic               overflow_q, frame_done_q;

  // in_done blocks any stray in_valid between the final sample and entering DRAIN
  assign sample     = (state == RUN) && in_valid && !in_done;
  assign qualify    = (row >= RW'(2)) && (col >= CW'(2));
  assign at_last_px = (row == RW'(IMG_HEIGHT - 1)) && (col == CW'(IMG_WIDTH - 1));
  assign shifted    = $signed(in_pixel) >>> shift_q;

  always_comb begin
    q_byte = shifted[7:0];
    if (relu_q) begin
      if (shifted < 0)               q_byte = 8'h00;
      else if (shifted > 32'sd255)   q_byte = 8'hFF;
    end else begin
      if (shifted < -32'sd128)       q_byte = 8'h80;
      else if (shifted > 32'sd127)   q_byte = 8'h7F;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (rq_valid && rq_last) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      in_done <= 1'b0;
    end else if (state == IDLE && start) begin
      col     <= '0;
      row     <= '0;
      shift_q <= shift_amt;
      relu_q  <= relu_en;
      in_done <= 1'b0;
    end else if (sample) begin
      if (at_last_px) in_done <= 1'b1;
      if (col == CW'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq_valid <= 1'b0;
      rq_last  <= 1'b0;
      rq_byte  <= '0;
    end else begin
      rq_valid <= sample && qualify;
      rq_last  <= at_last_px;
      rq_byte  <= q_byte;
    end
  end

  // Lanes above the current one are always zero, so a frame-end push is already padded
  always_comb begin
    push_word                   = pack_data;
    push_word[{lane, 3'b000} +: 8] = rq_byte;
    push_req                    = rq_valid && ((lane == 2'd3) || rq_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_data <= '0;
      lane      <= '0;
    end else if (state == IDLE && start) begin
      pack_data <= '0;
      lane      <= '0;
    end else if (rq_valid) begin
      if (push_req) begin
        pack_data <= '0;
        lane      <= '0;
      end else begin
        pack_data <= push_word;
        lane      <= lane + 2'd1;
      end
    end
  end

  assign fifo_empty = (count == '0);
  assign pop        = !fifo_empty && m_ready;
  assign push_ok    = push_req && ((count < (PW + 1)'(FIFO_DEPTH)) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {rq_last, push_word};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      count <= count + (PW + 1)'(1);
      else if (!push_ok && pop) count <= count - (PW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (state == IDLE && start)  overflow_q <= 1'b0;
      else if (push_req && !push_ok) overflow_q <= 1'b1;
      frame_done_q <= (state == DRAIN) && fifo_empty;
    end
  end

  assign m_valid    = !fifo_empty;
  assign m_data     = fifo_empty ? 32'd0 : mem[rd_ptr][31:0];
  assign m_last     = fifo_empty ? 1'b0  : mem[rd_ptr][32];
  assign overflow   = overflow_q;
  assign busy       = (state != IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_result_packer.sv
// Randomized bench for conv_result_packer: a byte-list packing model predicts the
// word stream, which a negedge monitor compares against every accepted transfer.
module tb_conv_result_packer;

  localparam int W    = 7;
  localparam int H    = 5;
  localparam int D    = 2;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  shift_amt = '0;
  logic        relu_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pixel = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_last;
  logic        overflow;
  logic        busy;
  logic        frame_done;

  int          checks = 0;
  int          errors = 0;
  int          fd_count = 0;
  int          ready_mode = 0;
  int          low_run = 0;
  int          pix [NPIX];
  int          special [12] = '{300, -300, -5, 1000, -7, 0, 127, 128, -128, -129, 255, 256};
  logic [32:0] exp_q [$];
  logic [32:0] model_words [$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  conv_result_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .shift_amt(shift_amt), .relu_en(relu_en),
    .in_valid(in_valid), .in_pixel(in_pixel), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .overflow(overflow), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] requantRef(input int px, input int sh, input bit relu);
    int v;
    v = px >>> sh;
    if (relu) begin
      if (v < 0)   return 8'h00;
      if (v > 255) return 8'hFF;
    end else begin
      if (v < -128) return 8'h80;
      if (v > 127)  return 8'h7F;
    end
    return v[7:0];
  endfunction

  // Kept pixels form a flat byte list; words are consecutive groups of four
  task automatic buildModel(input int sh, input bit relu);
    logic [7:0]  bytes [$];
    logic [31:0] w;
    model_words.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r >= 2 && c >= 2) bytes.push_back(requantRef(pix[r * W + c], sh, relu));
    for (int i = 0; i < bytes.size(); i += 4) begin
      w = '0;
      for (int k = 0; k < 4; k++)
        if (i + k < bytes.size()) w[8 * k +: 8] = bytes[i + k];
      model_words.push_back({(i + 4 >= bytes.size()), w});
    end
  endtask

  task automatic fillPixels(input int pmode);
    int p;
    for (int i = 0; i < NPIX; i++) begin
      p = int'($urandom);
      case (pmode)
        0:       pix[i] = i;
        1:       pix[i] = special[i % 12];
        default: pix[i] = p >>> $urandom_range(0, 28);
      endcase
    end
  endtask

  task automatic pulseStart(input int sh, input bit relu);
    @(posedge clk); #1;
    start = 1'b1; shift_amt = sh[4:0]; relu_en = relu;
    @(posedge clk); #1;
    start = 1'b0; shift_amt = 5'($urandom); relu_en = 1'($urandom);
  endtask

  task automatic feedPixels(input bit gaps, input bit mid_start, input int n);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        in_pixel = $urandom;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_pixel = pix[i];
      if (mid_start && i == 10) begin
        start = 1'b1; shift_amt = 5'd3;
      end
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0;
    end
  endtask

  task automatic waitDone(input int fd_start);
    for (int k = 0; k < 400 && fd_count == fd_start; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("frame_done_cnt", 64'(fd_count - fd_start), 1);
    checkOutput("words_left", 64'(exp_q.size()), 0);
    checkOutput("busy_idle", busy, 0);
    checkOutput("m_valid_idle", m_valid, 0);
    exp_q.delete();
  endtask

  task automatic applyStimulus(input int sh, input bit relu, input int pmode, input bit gaps,
                               input int rmode, input bit mid_start);
    int fd_start;
    fillPixels(pmode);
    buildModel(sh, relu);
    foreach (model_words[i]) exp_q.push_back(model_words[i]);
    ready_mode = rmode;
    fd_start = fd_count;
    pulseStart(sh, relu);
    feedPixels(gaps, mid_start, NPIX);
    waitDone(fd_start);
    checkOutput("overflow_clear", overflow, 0);
  endtask

  // Stalls are capped at two cycles so a depth-2 FIFO can never overflow
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: m_ready = 1'b0;
      1: m_ready = 1'b1;
      default: begin
        if (low_run >= 2) begin
          m_ready = 1'b1;
          low_run = 0;
        end else begin
          m_ready = ($urandom_range(0, 2) != 0);
          low_run = m_ready ? 0 : low_run + 1;
        end
      end
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_valid", m_valid, 1);
        checkOutput("hold_data", m_data, prev_data);
        checkOutput("hold_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_word", m_valid, 0);
        end else begin
          checkOutput("word_data", m_data, exp_q[0][31:0]);
          checkOutput("word_last", m_last, exp_q[0][32]);
          void'(exp_q.pop_front());
        end
      end
      if (frame_done) begin
        fd_count <= fd_count + 1;
        checkOutput("busy_at_done", busy, 0);
      end
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
      prev_last  <= m_last;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int fd_start;
    #2;
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_m_last", m_last, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] in_valid activity while idle");
    ready_mode = 1;
    repeat (40) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom);
      in_pixel = $urandom;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_m_valid", m_valid, 0);
    checkOutput("idle_busy", busy, 0);

    $display("[TB] index frame with start during RUN");
    applyStimulus(0, 1'b0, 0, 1'b0, 1, 1'b1);

    $display("[TB] saturation frames");
    applyStimulus(0, 1'b0, 1, 1'b1, 2, 1'b0);
    applyStimulus(0, 1'b1, 1, 1'b1, 2, 1'b0);
    applyStimulus(2, 1'b0, 1, 1'b1, 2, 1'b0);
    applyStimulus(2, 1'b1, 1, 1'b1, 2, 1'b0);
    applyStimulus(1, 1'b0, 1, 1'b1, 2, 1'b0);

    $display("[TB] random frames");
    repeat (6) applyStimulus($urandom_range(0, 12), 1'($urandom), 2, 1'b1, 2, 1'b0);

    $display("[TB] overflow with m_ready held low");
    fillPixels(0);
    buildModel(0, 1'b0);
    ready_mode = 0;
    fd_start = fd_count;
    pulseStart(0, 1'b0);
    feedPixels(1'b0, 1'b0, NPIX);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("ovf_valid", m_valid, 1);
    checkOutput("ovf_head", m_data, model_words[0][31:0]);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_busy", busy, 1);
    repeat (5) @(negedge clk);
    checkOutput("ovf_head_held", m_data, model_words[0][31:0]);
    checkOutput("ovf_no_done", 64'(fd_count - fd_start), 0);
    exp_q.push_back(model_words[0]);
    exp_q.push_back(model_words[1]);
    ready_mode = 1;
    waitDone(fd_start);
    checkOutput("ovf_sticky", overflow, 1);

    $display("[TB] reset in the middle of a frame");
    fillPixels(0);
    ready_mode = 1;
    fd_start = fd_count;
    pulseStart(0, 1'b0);
    feedPixels(1'b0, 1'b0, 10);
    #2;
    checkOutput("busy_pre_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_m_valid", m_valid, 0);
    checkOutput("mrst_m_data", m_data, 0);
    checkOutput("mrst_m_last", m_last, 0);
    checkOutput("mrst_overflow", overflow, 0);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_frame_done", frame_done, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    checkOutput("mrst_no_done", 64'(fd_count - fd_start), 0);
    applyStimulus(0, 1'b0, 0, 1'b1, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
